// File: rtl/mc_core_pkg.sv
// mc_core_pkg: opcodes, function codes, EBREAK word and FSM states shared by the mc_core blocks
package mc_core_pkg;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP = 7'b0110011;
  localparam logic [6:0] LUI = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] SYSTEM = 7'b1110011;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  typedef enum logic [2:0] {FETCH_REQ, FETCH_WAIT, EXEC, WB, HALT} state_t;
endpackage

// File: rtl/mc_core_regfile.sv
// mc_core_regfile: NR_REGS x XLEN GPR file, 2 async read ports, 1 sync write port, x0 reads zero
module mc_core_regfile
  import mc_core_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NR_REGS = 32,
  localparam int AW = $clog2(NR_REGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);
  logic [XLEN-1:0] gpr [NR_REGS];
  assign rd1 = ra1 == '0 ? '0 : gpr[ra1];
  assign rd2 = ra2 == '0 ? '0 : gpr[ra2];
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < NR_REGS; i++) gpr[i] <= '0;
    else if (we && wa != '0) gpr[wa] <= wd;
endmodule

// File: rtl/mc_core_top.sv
// mc_core_top: multicycle RV32I-subset core (addi/add/lui/auipc/jal/jalr/ebreak); perf counters under MC_CORE_PERF_CNT_EN
module mc_core_top
  import mc_core_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NR_REGS = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            imem_resp_ready,
  output logic            retire_valid_o,
  output logic [XLEN-1:0] retire_pc_o,
  output logic            halt_o,
  output logic            halt_illegal_o,
  output logic [XLEN-1:0] halt_code_o,
  output logic [63:0]     cycle_cnt_o,
  output logic [63:0]     instret_cnt_o
);
  localparam int AW = $clog2(NR_REGS);
  localparam logic [4:0] HI_MASK = ~5'(NR_REGS - 1);
  state_t state, state_n;
  logic [31:0] ir;
  logic [XLEN-1:0] pc, npc, npc_q, res, res_q, rs1_v, rs2_v, imm_i, imm_u, imm_j, halt_code;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2, rd_q;
  logic wen, wen_q, ill, ill_q, brk, brk_q, halt_ill;
  assign opc = ir[6:0];
  assign rd = ir[11:7];
  assign f3 = ir[14:12];
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign f7 = ir[31:25];
  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_u = {ir[31:12], 12'b0};
  assign imm_j = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
  mc_core_regfile #(.XLEN(XLEN), .NR_REGS(NR_REGS)) u_rf (
    .clk(clk),
    .rst(rst),
    .ra1(state == WB ? AW'(10) : rs1[AW-1:0]),
    .ra2(rs2[AW-1:0]),
    .we(state == WB && wen_q),
    .wa(rd_q[AW-1:0]),
    .wd(res_q),
    .rd1(rs1_v),
    .rd2(rs2_v)
  );
  always_comb begin
    res = '0;
    npc = pc + XLEN'(4);
    wen = 1'b1;
    ill = 1'b0;
    brk = 1'b0;
    case (opc)
      OP_IMM: begin res = rs1_v + imm_i; ill = f3 != F3_ADD || |((rd | rs1) & HI_MASK); end
      OP: begin res = rs1_v + rs2_v; ill = f3 != F3_ADD || f7 != F7_ADD || |((rd | rs1 | rs2) & HI_MASK); end
      LUI: begin res = imm_u; ill = |(rd & HI_MASK); end
      AUIPC: begin res = pc + imm_u; ill = |(rd & HI_MASK); end
      JAL: begin res = pc + XLEN'(4); npc = pc + imm_j; ill = |(rd & HI_MASK); end
      JALR: begin res = pc + XLEN'(4); npc = (rs1_v + imm_i) & ~XLEN'(1); ill = f3 != F3_JALR || |((rd | rs1) & HI_MASK); end
      SYSTEM: begin wen = 1'b0; brk = ir == EBREAK; ill = ir != EBREAK; end
      default: begin wen = 1'b0; ill = 1'b1; end
    endcase
  end
  always_comb begin
    state_n = state;
    case (state)
      FETCH_REQ: state_n = imem_req_ready ? FETCH_WAIT : FETCH_REQ;
      FETCH_WAIT: state_n = imem_resp_valid ? EXEC : FETCH_WAIT;
      EXEC: state_n = WB;
      WB: state_n = ill_q || brk_q ? HALT : FETCH_REQ;
      default: state_n = HALT;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= FETCH_REQ;
      pc <= RESET_PC;
      ir <= '0;
      res_q <= '0;
      rd_q <= '0;
      wen_q <= 1'b0;
      npc_q <= '0;
      ill_q <= 1'b0;
      brk_q <= 1'b0;
      halt_ill <= 1'b0;
      halt_code <= '0;
    end else begin
      state <= state_n;
      if (state == FETCH_WAIT && imem_resp_valid) ir <= imem_resp_data;
      if (state == EXEC) begin
        res_q <= res;
        rd_q <= rd;
        wen_q <= wen && !ill;
        npc_q <= npc;
        ill_q <= ill;
        brk_q <= brk;
      end
      if (state == WB) begin
        pc <= npc_q;
        halt_ill <= ill_q;
        if (brk_q) halt_code <= rs1_v;
      end
    end
  assign imem_req_valid = !rst && state == FETCH_REQ;
  assign imem_req_addr = rst ? '0 : pc;
  assign imem_resp_ready = !rst && state == FETCH_WAIT;
  assign retire_valid_o = !rst && state == WB && !ill_q;
  assign retire_pc_o = rst ? '0 : pc;
  assign halt_o = !rst && state == HALT;
  assign halt_illegal_o = !rst && halt_ill;
  assign halt_code_o = rst ? '0 : halt_code;
`ifdef MC_CORE_PERF_CNT_EN
  logic [63:0] cyc, ins;
  always_ff @(posedge clk)
    if (rst) begin
      cyc <= '0;
      ins <= '0;
    end else begin
      if (state != HALT) cyc <= cyc + 64'd1;
      if (retire_valid_o) ins <= ins + 64'd1;
    end
  assign cycle_cnt_o = rst ? '0 : cyc;
  assign instret_cnt_o = rst ? '0 : ins;
`else
  assign cycle_cnt_o = '0;
  assign instret_cnt_o = '0;
`endif
endmodule

// File: doc/mc_core_top.md
Name: mc_core_top

Overview:
- Parametrised multicycle RV32I-subset core top. Successor to the fixed addi-only IFU/MEM/GPR/EXU/WBU chain.
- Sequences fetch, execute and writeback with an explicit FSM.
- Instruction memory sits outside the block, behind a valid/ready request/response interface.
- Supports addi, add, lui, auipc, jal, jalr and ebreak. Also reports retire and halt status to the simulation harness.

Parameters:
- XLEN, 32, datapath and PC width; only 32 is legal.
- NR_REGS, 32, GPR count; 32 (RV32I) or 16 (RV32E).
- RESET_PC, 32'h8000_0000, PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address (current PC)
- imem_resp_valid  in  1  instruction word valid
- imem_resp_data  in  32  instruction word
- imem_resp_ready  out  1  core accepts response
- retire_valid_o  out  1  one-cycle pulse per retired instruction
- retire_pc_o  out  XLEN  PC of the retired instruction
- halt_o  out  1  core halted; sticky until rst
- halt_illegal_o  out  1  halt was caused by an illegal instruction
- halt_code_o  out  XLEN  value of x10 (a0) captured at halt
- cycle_cnt_o  out  64  cycle counter (feature-gated)
- instret_cnt_o  out  64  retired-instruction counter (feature-gated)

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=FETCH_REQ, PC=RESET_PC, all GPRs=0.
  - All outputs 0; imem_req_valid and imem_resp_ready held 0 while rst=1.
  - Reset mid-fetch abandons the transaction; the memory shares rst and drops it too.
- FETCH_REQ:
  - imem_req_valid=1, imem_req_addr=PC.
  - On valid&&ready: go to FETCH_WAIT. Otherwise hold; address stays stable while waiting.
- FETCH_WAIT:
  - imem_resp_ready=1.
  - On resp_valid: latch the instruction into IR, go to EXEC.
  - A response is never accepted in the same cycle as its request.
- EXEC (1 cycle):
  - Decode IR, read rs1/rs2, compute result and next_pc.
  - Register into result/rd/wen/next_pc, go to WB.
- WB (1 cycle):
  - Write GPR[rd] if wen && rd!=0; x0 always reads 0.
  - PC <= next_pc.
  - Pulse retire_valid_o with retire_pc_o = the old PC.
  - Go to FETCH_REQ.
- Minimum latency: 4 cycles per instruction with zero-wait memory.
- Arithmetic:
  - All ops mod 2^32; immediates sign-extended per the RV32I formats.
  - jal/jalr write PC+4 to rd.
  - jalr target = (rs1+imm) & ~1.
  - No misaligned-target trap.
- ebreak: in WB, capture GPR[10] into halt_code_o, set halt_o=1, go to HALT. ebreak counts as retired.
- Illegal instruction:
  - Covers any unsupported opcode/funct3/funct7, and any rd/rs1/rs2 index >= NR_REGS.
  - In WB: halt_o=1, halt_illegal_o=1, no GPR write, no retire pulse, go to HALT.
- HALT: no requests issued, state frozen; only rst exits.
- Read-after-write: the WB write is visible to the next instruction's EXEC. There is no same-cycle overlap, so no bypass is needed.

Optional Feature:
- Macro: MC_CORE_PERF_CNT_EN.
- Defined:
  - cycle_cnt_o increments every non-reset cycle until halt, then freezes.
  - instret_cnt_o increments on each retire_valid_o.
  - Both are 64-bit, wrap at 2^64, and reset to 0.
- Undefined: both ports tied to 0; no counter flops synthesised.

Decomposition:
- Package mc_core_pkg:
  - opcode constants (OP_IMM, OP, LUI, AUIPC, JAL, JALR, SYSTEM);
  - funct3/funct7 constants;
  - FSM state enum (FETCH_REQ, FETCH_WAIT, EXEC, WB, HALT);
  - EBREAK encoding 32'h0010_0073.
- Sub-module mc_core_regfile:
  - parametrised by XLEN and NR_REGS;
  - 2 async read ports, 1 sync write port;
  - x0 hardwired to 0; synchronous reset clears all registers.

Test Plan:
- Zero-wait memory; addi x1,x0,5 then ebreak → retire pulses at cycles 4 and 8; x1=5; halt_o=1; halt_code_o=0.
- imem_req_ready low for 3 cycles, resp delayed 2 cycles → imem_req_addr stable at 32'h8000_0000 throughout; retire only after the response; no duplicate fetch.
- lui x10,0x12345 + addi x10,x10,0x678 + ebreak → halt_code_o=32'h1234_5678.
- jal x1,+8 at 32'h8000_0000 → x1=32'h8000_0004; next imem_req_addr=32'h8000_0008. Then jalr x0,0(x1) → next address 32'h8000_0004.
- NR_REGS=16, addi x20,x0,1 → halt_illegal_o=1; no retire pulse; no GPR change. Word 32'hFFFF_FFFF behaves the same.
- rst asserted in FETCH_WAIT, then released → next imem_req_addr=RESET_PC; GPRs=0; with MC_CORE_PERF_CNT_EN, both counters=0.
